// File: rtl/seq_divider_32_pkg.sv
// Shared definitions for the sequential restoring divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_divider_32_pkg;

  localparam int DIV_WIDTH = 32;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_32_step.sv
// One restoring division iteration: shift {R,Q} left, trial-subtract divisor, restore on borrow.
// Latency: purely combinational.
// Backpressure: none.
module div_step_32
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic             unused_diff_hi;

  // Shifted partial remainder is WIDTH+1 bits; the subtract carries one extra bit as borrow-out.
  always_comb begin
    r_sh   = {r_in, q_in[WIDTH-1]};
    diff   = {1'b0, r_sh} - {2'b00, divisor};
    borrow = diff[WIDTH+1];
    q_out  = {q_in[WIDTH-2:0], ~borrow};
    // When no borrow the true difference is below the divisor, so it fits in WIDTH bits.
    r_out  = borrow ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  // Bit WIDTH of the difference is always zero when it is selected.
  assign unused_diff_hi = diff[WIDTH];

endmodule

// File: rtl/seq_divider_32.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per clock.
// Latency: done pulses 33 cycles after the start cycle (1 cycle after it for divide-by-zero).
// Backpressure: start is only taken in IDLE or DONE; it is ignored while busy.
module seq_divider_32
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t       state, state_nxt;
  logic             accept;
  logic             last_step;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r_wk, q_wk, d_wk;
  logic [WIDTH-1:0] r_step, q_step;

  div_step_32 #(.WIDTH(WIDTH)) u_step (
    .r_in    (r_wk),
    .q_in    (q_wk),
    .divisor (d_wk),
    .r_out   (r_step),
    .q_out   (q_step)
  );

  assign last_step = (cnt == CNT_W'(1));
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DONE behaves like IDLE for start so operations can run back to back.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (start) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_step) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Working registers iterate during RUN; visible results are only written on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      r_wk        <= '0;
      q_wk        <= '0;
      d_wk        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        quotient    <= {WIDTH{1'b1}};
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        q_wk        <= dividend;
        r_wk        <= '0;
        d_wk        <= divisor;
        cnt         <= CNT_W'(WIDTH);
        div_by_zero <= 1'b0;
      end
    end else if (state == ST_RUN) begin
      q_wk <= q_step;
      r_wk <= r_step;
      cnt  <= cnt - CNT_W'(1);
      if (last_step) begin
        quotient  <= q_step;
        remainder <= r_step;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_32.sv
module tb_seq_divider_32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  // Results the outputs must hold while a new operation is still running.
  logic [W-1:0] exp_prev_q = '0;
  logic [W-1:0] exp_prev_r = '0;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t tbl[8];

  seq_divider_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division, divide-by-zero gives all ones and the dividend back.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
  endtask

  // Counts cycles from the start cycle until done is seen; optionally re-issues start
  // mid-run, or issues a chained start inside the done cycle.
  task automatic wait_done(input int reissue_at, input bit chain,
                           input logic [W-1:0] ca, input logic [W-1:0] cb,
                           output int lat, output int busy_cnt, output bit hold_bad);
    lat = 0; busy_cnt = 0; hold_bad = 1'b0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (lat == reissue_at) go(ca, cb);
      if (done) break;
      if (busy) busy_cnt++;
      if (quotient !== exp_prev_q || remainder !== exp_prev_r) hold_bad = 1'b1;
    end
    if (chain && done) go(ca, cb);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                              input logic ez, input int elat,
                              input int lat, input int busy_cnt, input bit hold_bad);
    chk({tag, "_lat"},     64'(lat), 64'(elat));
    chk({tag, "_q"},       64'(quotient), 64'(eq));
    chk({tag, "_r"},       64'(remainder), 64'(er));
    chk({tag, "_dbz"},     64'(div_by_zero), 64'(ez));
    chk({tag, "_busy_n"},  64'(busy_cnt), ez ? 64'd0 : 64'd32);
    chk({tag, "_busy_dn"}, 64'(busy), 64'd0);
    chk({tag, "_hold"},    64'(hold_bad), 64'd0);
    exp_prev_q = eq;
    exp_prev_r = er;
  endtask

  task automatic pulse_check(input string tag);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_keep"}, {quotient, remainder}, {exp_prev_q, exp_prev_r});
  endtask

  initial begin
    int lat, bc;
    bit hb;
    logic [W-1:0] a, b, mq, mr;
    logic mz;

    tbl[0] = '{dvd: 32'd100,        dvs: 32'd7,          q: 32'd14,         r: 32'd2,          dbz: 1'b0, lat: 33};
    tbl[1] = '{dvd: 32'h12345678,   dvs: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'h1234_5678,  dbz: 1'b1, lat: 1};
    tbl[2] = '{dvd: 32'hFFFF_FFFF,  dvs: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          dbz: 1'b0, lat: 33};
    tbl[3] = '{dvd: 32'd5,          dvs: 32'd9,          q: 32'd0,          r: 32'd5,          dbz: 1'b0, lat: 33};
    tbl[4] = '{dvd: 32'hFFFF_FFFF,  dvs: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,          dbz: 1'b0, lat: 33};
    tbl[5] = '{dvd: 32'd0,          dvs: 32'd5,          q: 32'd0,          r: 32'd0,          dbz: 1'b0, lat: 33};
    tbl[6] = '{dvd: 32'h8000_0000,  dvs: 32'd3,          q: 32'h2AAA_AAAA,  r: 32'd2,          dbz: 1'b0, lat: 33};
    tbl[7] = '{dvd: 32'd0,          dvs: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd0,          dbz: 1'b1, lat: 1};

    // Reset held with a start request pending: reset must win.
    go(32'd50, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_start_busy", 64'(busy), 64'd0);
      chk("rst_start_done", 64'(done), 64'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;

    // Idle after reset: everything stays zero.
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk("idle", {busy, done, div_by_zero, quotient, remainder}, 64'd0);
    end

    // Table of directed vectors.
    for (int i = 0; i < 8; i++) begin
      go(tbl[i].dvd, tbl[i].dvs);
      wait_done(-1, 1'b0, '0, '0, lat, bc, hb);
      check_result($sformatf("vec%0d", i), tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].lat, lat, bc, hb);
      pulse_check($sformatf("vec%0d", i));
    end

    // Start during RUN is ignored.
    go(32'd100, 32'd7);
    wait_done(10, 1'b0, 32'd1234, 32'd1, lat, bc, hb);
    check_result("ignore_run", 32'd14, 32'd2, 1'b0, 33, lat, bc, hb);
    pulse_check("ignore_run");

    // Start in the DONE cycle is accepted (back to back).
    go(32'd100, 32'd7);
    wait_done(-1, 1'b1, 32'd81, 32'd9, lat, bc, hb);
    check_result("b2b_first", 32'd14, 32'd2, 1'b0, 33, lat, bc, hb);
    wait_done(-1, 1'b0, '0, '0, lat, bc, hb);
    check_result("b2b_second", 32'd9, 32'd0, 1'b0, 33, lat, bc, hb);
    pulse_check("b2b_second");

    // Reset in the middle of RUN: immediate return to idle, outputs cleared, no done.
    go(32'd200, 32'd3);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("mid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clear", {busy, done, div_by_zero, quotient, remainder}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_nodone", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    exp_prev_q = '0;
    exp_prev_r = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("mid_post_idle", {busy, done}, 64'd0);
    end
    go(32'd1000, 32'd10);
    wait_done(-1, 1'b0, '0, '0, lat, bc, hb);
    check_result("after_rst", 32'd100, 32'd0, 1'b0, 33, lat, bc, hb);

    // Random operands against the reference, issued back to back.
    for (int n = 0; n < 1200; n++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 63) == 0) b = '0;
      if ($urandom_range(0, 15) == 0) a = a >> $urandom_range(0, 31);
      ref_div(a, b, mq, mr, mz);
      go(a, b);
      wait_done(-1, 1'b0, '0, '0, lat, bc, hb);
      chk("rand_q",   64'(quotient), 64'(mq));
      chk("rand_r",   64'(remainder), 64'(mr));
      chk("rand_dbz", 64'(div_by_zero), 64'(mz));
      chk("rand_lat", 64'(lat), mz ? 64'd1 : 64'd33);
      chk("rand_hold", 64'(hb), 64'd0);
      if (!mz) begin
        chk("rand_inv",
            {62'd0, (64'(quotient) * 64'(b) + 64'(remainder)) == 64'(a), remainder < b},
            64'd3);
      end
      exp_prev_q = mq;
      exp_prev_r = mr;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
